// File: rtl/wr_ptr_full.sv
// Write-side pointer and flag generator for a dual-clock Gray-pointer FIFO.
// Owns the binary write address and the Gray write pointer that crosses into
// the read domain. Derives full, almost-full and the fill level from the read
// pointer, which arrives already double-synchronised into wr_clk.
// Optional feature: define FIFO_WR_OVERFLOW_EN to build the sticky
// write-while-full detector. Without it, overflow_o is tied low.
module wr_ptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                  wr_clk_i,
    input  logic                  wr_rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   wq2_rptr_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH:0]   wr_ptr_o,
    output logic                  full_o,
    output logic                  a_full_o,
    output logic [ADDR_WIDTH:0]   wr_level_o,
    output logic                  overflow_o
);

    localparam int                DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);
    // In Gray code, "one lap ahead" means the top two bits are inverted and
    // the rest are equal.
    localparam logic [ADDR_WIDTH:0] FULL_MASK   = {2'b11, {(ADDR_WIDTH-1){1'b0}}};

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbinnext;
    logic [ADDR_WIDTH:0] wgraynext;
    logic [ADDR_WIDTH:0] rbin_s;
    logic [ADDR_WIDTH:0] level_next;
    logic                inc;
    logic                full_val;

    // Accept a write only while not full, and compute the next pointers and level.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        rbin_s = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin_s[i] = ^(wq2_rptr_i >> i);
        end
        inc        = wr_en_i & ~full_o;
        wbinnext   = wbin + {{ADDR_WIDTH{1'b0}}, inc};
        wgraynext  = (wbinnext >> 1) ^ wbinnext;
        full_val   = (wgraynext == (wq2_rptr_i ^ FULL_MASK));
        level_next = wbinnext - rbin_s;
    end

    assign wr_addr_o = wbin[ADDR_WIDTH-1:0];

    // Pointer, flag and level registers with synchronous reset.
    always_ff @(posedge wr_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (wr_rst_i) begin
            wbin       <= '0;
            wr_ptr_o   <= '0;
            full_o     <= 1'b0;
            a_full_o   <= 1'b0;
            wr_level_o <= '0;
        end else begin
            wbin       <= wbinnext;
            wr_ptr_o   <= wgraynext;
            full_o     <= full_val;
            a_full_o   <= (level_next >= AFULL_LEVEL);
            wr_level_o <= level_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    // Sticky record of any write attempted while full; only reset clears it.
    always_ff @(posedge wr_clk_i) begin
        if (wr_rst_i) begin
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= overflow_o | (wr_en_i & full_o);
        end
    end
`else
    assign overflow_o = 1'b0;
`endif

    // Full must agree with the level, and the Gray pointer must move at most one bit per edge.
    always @(posedge wr_clk_i) begin
        if (!wr_rst_i) begin
            assert (full_o == (wr_level_o == FULL_LEVEL));
            assert ($countones(wr_ptr_o ^ wgraynext) <= 1);
        end
    end

endmodule

// File: tb/tb_wr_ptr_full.sv
// Directed and random self-checking bench for wr_ptr_full at ADDR_WIDTH=2.
module tb_wr_ptr_full;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] rptr;
    logic [1:0] addr;
    logic [2:0] ptr;
    logic       full;
    logic       afull;
    logic [2:0] level;
    logic       ovf;

    int tests;
    int failed;

    // Overflow reference value depends on which build is compiled.
`ifdef FIFO_WR_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    wr_ptr_full #(.ADDR_WIDTH(2), .AFULL_MARGIN(1)) dut (
        .wr_clk_i   (clk),
        .wr_rst_i   (rst),
        .wr_en_i    (en),
        .wq2_rptr_i (rptr),
        .wr_addr_o  (addr),
        .wr_ptr_o   (ptr),
        .full_o     (full),
        .a_full_o   (afull),
        .wr_level_o (level),
        .overflow_o (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_addr, input logic [2:0] e_ptr,
                             input logic e_full, input logic e_afull, input logic [2:0] e_level,
                             input logic e_ovf);
        check({tag, ".addr"},  32'(addr),  32'(e_addr));
        check({tag, ".ptr"},   32'(ptr),   32'(e_ptr));
        check({tag, ".full"},  32'(full),  32'(e_full));
        check({tag, ".afull"}, 32'(afull), 32'(e_afull));
        check({tag, ".level"}, 32'(level), 32'(e_level));
        check({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    endtask

    function automatic logic [2:0] gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [2:0] wbin_m;
        logic [2:0] rbin_m;
        logic [2:0] lvl_m;
        logic [2:0] prev_ptr;
        logic       full_cur;

        tests  = 0;
        failed = 0;

        // Reset with write enable held high: nothing may advance.
        rst  = 1'b1;
        en   = 1'b1;
        rptr = 3'b000;
        tick();
        check_all("reset1", 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        check_all("reset2", 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);

        // Fill: four writes; addresses 0..3 seen before each accepting edge.
        rst = 1'b0;
        check("fill0.addr_pre", 32'(addr), 32'd0);
        tick();
        check_all("fill1", 2'd1, 3'b001, 1'b0, 1'b0, 3'd1, 1'b0);
        tick();
        check_all("fill2", 2'd2, 3'b011, 1'b0, 1'b0, 3'd2, 1'b0);
        tick();
        check_all("fill3", 2'd3, 3'b010, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        check_all("fill4", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b0);

        // Fifth write while full is ignored; overflow is sticky when built.
        tick();
        check_all("ovf_wr", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, OVF_ON);
        en = 1'b0;
        tick();
        check_all("ovf_hold", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, OVF_ON);

        // Read side has consumed three entries (read bin 3 = Gray 010).
        rptr = 3'b010;
        tick();
        check_all("drain", 2'd0, 3'b110, 1'b0, 1'b0, 3'd1, OVF_ON);

        // Refill three slots: addresses 0,1,2, back to full at level 4.
        en = 1'b1;
        tick();
        check_all("refill1", 2'd1, 3'b111, 1'b0, 1'b0, 3'd2, OVF_ON);
        tick();
        check_all("refill2", 2'd2, 3'b101, 1'b0, 1'b1, 3'd3, OVF_ON);
        tick();
        check_all("refill3", 2'd3, 3'b100, 1'b1, 1'b1, 3'd4, OVF_ON);

        // Read pointer advances to bin 4 then bin 5 with no writes.
        en   = 1'b0;
        rptr = 3'b110;
        tick();
        check_all("rd4", 2'd3, 3'b100, 1'b0, 1'b1, 3'd3, OVF_ON);
        rptr = 3'b111;
        tick();
        check_all("rd5", 2'd3, 3'b100, 1'b0, 1'b0, 3'd2, OVF_ON);

        // Simultaneous write and read advance at level 2; write pointer wraps 7->0.
        en   = 1'b1;
        rptr = 3'b101;
        tick();
        check_all("simul_wrap", 2'd0, 3'b000, 1'b0, 1'b0, 3'd2, OVF_ON);

        // Random traffic against a reference model with a legal read pointer.
        en   = 1'b0;
        rst  = 1'b1;
        rptr = 3'b000;
        tick();
        rst      = 1'b0;
        wbin_m   = 3'd0;
        rbin_m   = 3'd0;
        lvl_m    = 3'd0;
        prev_ptr = 3'b000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            en = 1'($urandom_range(0, 1));
            if (rbin_m != wbin_m && $urandom_range(0, 1) == 1) rbin_m = rbin_m + 3'd1;
            rptr     = gray(rbin_m);
            full_cur = (lvl_m == 3'd4);
            if (en && !full_cur) wbin_m = wbin_m + 3'd1;
            tick();
            lvl_m = wbin_m - rbin_m;
            check("rnd.level", 32'(level), 32'(lvl_m));
            check("rnd.full", 32'(full), 32'(lvl_m == 3'd4));
            check("rnd.afull", 32'(afull), 32'(lvl_m >= 3'd3));
            check("rnd.ptr", 32'(ptr), 32'(gray(wbin_m)));
            check("rnd.full_inv", 32'(full), 32'(level == 3'd4));
            check("rnd.ptr_1bit", 32'($countones(ptr ^ prev_ptr) <= 1), 32'd1);
            prev_ptr = ptr;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
